// File: rtl/membrane_pkg.sv
// Shared constants for the membrane keyboard scanner: matrix geometry and scan states.
package membrane_pkg;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 7;
    localparam int ZX_COLS  = 5;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_WAIT    = 2'd0;
    localparam scan_state_t ST_SETTLE  = 2'd1;
    localparam scan_state_t ST_SAMPLE  = 2'd2;
    localparam scan_state_t ST_ADVANCE = 2'd3;

    function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [2:0] row);
        return NUM_ROWS'(1) << row;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key's debounce: a 2-bit agreement counter plus the debounced state bit.
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic sysclk,
    input  logic reset,
    input  logic sample_en,
    input  logic raw,
    output logic state,
    output logic flip
);

    localparam logic [1:0] CNT_LAST = 2'(DEBOUNCE_SCANS - 1);

    logic [1:0] cnt_q, cnt_d;
    logic       state_q, state_d;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        flip    = 1'b0;
        if (sample_en) begin
            if (raw == state_q) begin
                cnt_d = 2'd0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = ~state_q;
                cnt_d   = 2'd0;
                flip    = 1'b1;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/membrane_scanner.sv
// Membrane keyboard scanner: row sequencing, column sampling, per-key debounce
// and the registered port 0xFE read mux.
//
// state      | meaning
// WAIT       | all rows released for one slot after reset
// SETTLE     | one row driven, columns settling (ROW_TICKS-2 cycles)
// SAMPLE     | row still driven, synchronized columns captured into debounce
// ADVANCE    | no row driven (break-before-make), row index steps
module membrane_scanner
    import membrane_pkg::*;
#(
    parameter int ROW_TICKS      = 512,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        sysclk,
    input  logic        reset,
    output logic [7:0]  keyb_row_drive,
    input  logic [6:0]  keyb_col_i,
    input  logic [7:0]  zx_addr_hi,
    output logic [4:0]  zx_cols,
    output logic [1:0]  ext_cols,
    output logic [55:0] key_matrix,
    output logic        frame_done,
    output logic        key_event
);

    localparam int TW = $clog2(ROW_TICKS);
    localparam logic [TW-1:0] WAIT_LOAD   = TW'(ROW_TICKS - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(ROW_TICKS - 3);

    scan_state_t          state_q, state_d;
    logic [2:0]           row_q, row_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_ROWS-1:0]  drive_q, drive_d;
    logic [NUM_COLS-1:0]  col_meta_q, col_meta_d;
    logic [NUM_COLS-1:0]  col_sync_q, col_sync_d;
    logic                 frame_done_q, frame_done_d;
    logic                 key_event_q, key_event_d;
    logic [ZX_COLS-1:0]   zx_cols_q, zx_cols_d;
    logic [NUM_COLS-ZX_COLS-1:0] ext_cols_q, ext_cols_d;

    logic [NUM_KEYS-1:0]  key_state;
    logic [NUM_KEYS-1:0]  key_flip;
    logic [NUM_COLS-1:0]  port_hit;

    assign col_meta_d = keyb_col_i;
    assign col_sync_d = col_meta_q;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        timer_d      = timer_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (timer_q == '0) begin
                    state_d = ST_SETTLE;
                    row_d   = 3'd0;
                    timer_d = SETTLE_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                state_d      = ST_ADVANCE;
                frame_done_d = (row_q == 3'd7);
            end
            ST_ADVANCE: begin
                state_d = ST_SETTLE;
                row_d   = row_q + 3'd1;
                timer_d = SETTLE_LOAD;
            end
            default: begin
                state_d = ST_WAIT;
                row_d   = 3'd0;
                timer_d = WAIT_LOAD;
            end
        endcase
        drive_d = (state_d == ST_SETTLE || state_d == ST_SAMPLE) ? row_onehot(row_d) : '0;
    end

    // Each key only listens during the SAMPLE cycle of its own row.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            key_debounce #(
                .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
            ) u_key (
                .sysclk    (sysclk),
                .reset     (reset),
                .sample_en (state_q == ST_SAMPLE && row_q == 3'(r)),
                .raw       (~col_sync_q[c]),
                .state     (key_state[r*NUM_COLS + c]),
                .flip      (key_flip[r*NUM_COLS + c])
            );
        end
    end

    assign key_event_d = |key_flip;

    always_comb begin
        port_hit = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!zx_addr_hi[r]) begin
                port_hit = port_hit | key_state[r*NUM_COLS +: NUM_COLS];
            end
        end
        zx_cols_d  = ~port_hit[ZX_COLS-1:0];
        ext_cols_d = ~port_hit[NUM_COLS-1:ZX_COLS];
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_WAIT;
            row_q        <= 3'd0;
            timer_q      <= WAIT_LOAD;
            drive_q      <= '0;
            col_meta_q   <= '1;
            col_sync_q   <= '1;
            frame_done_q <= 1'b0;
            key_event_q  <= 1'b0;
            zx_cols_q    <= '1;
            ext_cols_q   <= '1;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            timer_q      <= timer_d;
            drive_q      <= drive_d;
            col_meta_q   <= col_meta_d;
            col_sync_q   <= col_sync_d;
            frame_done_q <= frame_done_d;
            key_event_q  <= key_event_d;
            zx_cols_q    <= zx_cols_d;
            ext_cols_q   <= ext_cols_d;
        end
    end

    assign keyb_row_drive = drive_q;
    assign key_matrix     = key_state;
    assign zx_cols        = zx_cols_q;
    assign ext_cols       = ext_cols_q;
    assign frame_done     = frame_done_q;
    assign key_event      = key_event_q;

endmodule

// File: tb/tb_membrane_scanner.sv
// Directed bench for membrane_scanner with ROW_TICKS=16, DEBOUNCE_SCANS=3 and a simple membrane model.
module tb_membrane_scanner;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [7:0]  keyb_row_drive;
    logic [6:0]  keyb_col_i;
    logic [7:0]  zx_addr_hi;
    logic [4:0]  zx_cols;
    logic [1:0]  ext_cols;
    logic [55:0] key_matrix;
    logic        frame_done;
    logic        key_event;

    logic [55:0] pressed;
    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int ev_count = 0;

    always #5 sysclk = ~sysclk;

    membrane_scanner #(
        .ROW_TICKS      (16),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .keyb_row_drive (keyb_row_drive),
        .keyb_col_i     (keyb_col_i),
        .zx_addr_hi     (zx_addr_hi),
        .zx_cols        (zx_cols),
        .ext_cols       (ext_cols),
        .key_matrix     (key_matrix),
        .frame_done     (frame_done),
        .key_event      (key_event)
    );

    // A pressed key pulls its column low only while its row is driven.
    always_comb begin
        keyb_col_i = '1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 7; c++) begin
                if (pressed[r*7 + c] && keyb_row_drive[r]) keyb_col_i[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        @(negedge sysclk);
        cyc++;
        if (key_event === 1'b1) ev_count++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        reset      = 1'b1;
        pressed    = '0;
        zx_addr_hi = 8'hFF;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;

        chk("rst_drive", 64'(keyb_row_drive), 64'h00);
        chk("rst_matrix", 64'(key_matrix), 64'h0);
        chk("rst_zx", 64'(zx_cols), 64'h1F);
        chk("rst_ext", 64'(ext_cols), 64'h3);
        chk("rst_frame_done", 64'(frame_done), 64'h0);
        chk("rst_key_event", 64'(key_event), 64'h0);

        for (int i = 0; i < 16; i++) begin
            chk("wait_drive", 64'(keyb_row_drive), 64'h00);
            tick();
        end
        chk("row0_first", 64'(keyb_row_drive), 64'h01);
        run_to(30);
        chk("row0_sample", 64'(keyb_row_drive), 64'h01);
        run_to(31);
        chk("advance_bbm", 64'(keyb_row_drive), 64'h00);
        chk("advance_no_frame", 64'(frame_done), 64'h0);
        run_to(32);
        chk("row1_first", 64'(keyb_row_drive), 64'h02);
        run_to(142);
        chk("row7_sample", 64'(keyb_row_drive), 64'h80);
        chk("frame_done_pre", 64'(frame_done), 64'h0);
        run_to(143);
        chk("frame_done_1", 64'(frame_done), 64'h1);
        run_to(144);
        chk("frame_done_post", 64'(frame_done), 64'h0);
        chk("row0_wrap", 64'(keyb_row_drive), 64'h01);

        // Row 2 col 0 held: row-2 samples at 190, 318, 446.
        pressed[14] = 1'b1;
        ev_count = 0;
        run_to(271);
        chk("frame_done_2", 64'(frame_done), 64'h1);
        run_to(319);
        chk("deb_after2", 64'(key_matrix[14]), 64'h0);
        run_to(446);
        chk("deb_before3", 64'(key_matrix[14]), 64'h0);
        run_to(447);
        chk("deb_set", 64'(key_matrix), 64'h0000_0000_0000_4000);
        chk("event_pulse", 64'(key_event), 64'h1);
        run_to(448);
        chk("event_once", 64'(key_event), 64'h0);
        chk("event_count", 64'(ev_count), 64'h1);
        chk("zx_none_sel", 64'(zx_cols), 64'h1F);

        run_to(450);
        zx_addr_hi = 8'hFB;
        chk("zx_latency", 64'(zx_cols), 64'h1F);
        tick();
        chk("zx_row2", 64'(zx_cols), 64'h1E);
        chk("ext_row2", 64'(ext_cols), 64'h3);
        zx_addr_hi = 8'h7F;
        tick();
        chk("zx_row7", 64'(zx_cols), 64'h1F);
        zx_addr_hi = 8'h00;
        tick();
        chk("zx_all_a", 64'(zx_cols), 64'h1E);
        zx_addr_hi = 8'hFF;

        // Release row2 col0; press row0 col1, row7 col1, row3 col5.
        run_to(460);
        pressed[14] = 1'b0;
        pressed[1]  = 1'b1;
        pressed[50] = 1'b1;
        pressed[26] = 1'b1;
        run_to(850);
        chk("matrix_multi", 64'(key_matrix), 64'h0004_0000_0400_0002);
        zx_addr_hi = 8'h00;
        tick();
        chk("zx_all_b", 64'(zx_cols), 64'h1D);
        chk("ext_all", 64'(ext_cols), 64'h2);
        zx_addr_hi = 8'hF7;
        tick();
        chk("zx_row3", 64'(zx_cols), 64'h1F);
        chk("ext_row3", 64'(ext_cols), 64'h2);
        zx_addr_hi = 8'hFE;
        tick();
        chk("zx_row0", 64'(zx_cols), 64'h1D);
        chk("ext_row0", 64'(ext_cols), 64'h3);
        zx_addr_hi = 8'hFF;

        // Two agreeing frames then release: must not flip.
        run_to(855);
        ev_count = 0;
        pressed[14] = 1'b1;
        run_to(1100);
        pressed[14] = 1'b0;
        run_to(1230);
        chk("short_press", 64'(key_matrix[14]), 64'h0);
        chk("short_no_event", 64'(ev_count), 64'h0);
        chk("matrix_held", 64'(key_matrix), 64'h0004_0000_0400_0002);

        // Reset in the middle of row 4 SETTLE.
        run_to(1236);
        chk("row4_settle", 64'(keyb_row_drive), 64'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_drive", 64'(keyb_row_drive), 64'h00);
        chk("midrst_matrix", 64'(key_matrix), 64'h0);
        chk("midrst_zx", 64'(zx_cols), 64'h1F);
        run_to(1252);
        chk("midrst_wait_end", 64'(keyb_row_drive), 64'h00);
        run_to(1253);
        chk("midrst_row0", 64'(keyb_row_drive), 64'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/membrane_scanner.md
MEMBRANE_SCANNER -- requirements
Module: membrane_scanner

Interface
REQ-001 SHALL provide parameter ROW_TICKS, default 512, giving sysclk cycles per row slot (18.3 us at 28 MHz).
REQ-002 SHALL provide parameter DEBOUNCE_SCANS, default 3, giving the number of consecutive agreeing frames needed to change a key state (range 1..3).
REQ-003 SHALL have port: sysclk  input  1  system clock, single clock domain.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: keyb_row_drive  output  8  1 = drive row low; 0 = row high-Z (top level converts).
REQ-006 SHALL have port: keyb_col_i  input  7  raw membrane columns, asynchronous, active low, pulled up.
REQ-007 SHALL have port: zx_addr_hi  input  8  CPU A15..A8 for a port 0xFE read, active low row select.
REQ-008 SHALL have port: zx_cols  output  5  Spectrum key bits D4..D0, active low.
REQ-009 SHALL have port: ext_cols  output  2  extended columns 5..6 for the selected rows, active low.
REQ-010 SHALL have port: key_matrix  output  56  debounced state, 1 = pressed, bit index = row*7 + col.
REQ-011 SHALL have port: frame_done  output  1  one-cycle pulse after row 7 is sampled.
REQ-012 SHALL have port: key_event  output  1  one-cycle pulse when any key_matrix bit changes.

Function
REQ-013 SHALL pass keyb_col_i through a 2-flop synchronizer before any use.
REQ-014 SHALL use a state machine with states WAIT, SETTLE, SAMPLE, ADVANCE.
REQ-015 WAIT: all rows high-Z for ROW_TICKS cycles after reset, then go to SETTLE with row 0.
REQ-016 SETTLE: drive exactly one row, keyb_row_drive = one-hot(row); count ROW_TICKS-2 cycles, then go to SAMPLE.
REQ-017 SAMPLE: for one cycle, capture the inverted synchronized columns as the raw sample of the current row, with the row still driven.
REQ-018 ADVANCE: for one cycle, drive no rows (break-before-make) and increment row modulo 8.
REQ-019 On the 7->0 row wrap, ADVANCE SHALL pulse frame_done.
REQ-020 Each row slot SHALL be exactly ROW_TICKS cycles; each frame SHALL be exactly 8*ROW_TICKS cycles.
REQ-021 Each key SHALL have a 2-bit agreement counter.
REQ-022 Counter update: raw equal to debounced clears the counter; raw different increments it.
REQ-023 When a key's counter reaches DEBOUNCE_SCANS-1 and raw still differs, the key SHALL flip and its counter clear.
REQ-024 Debounce SHALL update only on the SAMPLE cycle of that key's own row.
REQ-025 key_event SHALL pulse in the cycle after any flip; several flips in the same SAMPLE give one pulse.
REQ-026 zx_cols[c] SHALL be NOT (OR over rows r with zx_addr_hi[r]=0 of key_matrix[r*7+c]), registered, with one-cycle latency.
REQ-027 ext_cols SHALL be formed the same way for columns 5..6.
REQ-028 zx_addr_hi = 0xFF SHALL give zx_cols = 5'b11111.
REQ-029 zx_addr_hi = 0x00 SHALL OR all eight rows.
REQ-030 A key flip and a zx_addr_hi change in the same cycle: zx_cols SHALL reflect the new key_matrix one cycle later.
REQ-031 Ghosting SHALL NOT be masked; raw matrix values are reported as sampled.

Reset
REQ-032 Reset SHALL set: state WAIT, row 0, keyb_row_drive 0, key_matrix 0, all counters 0, zx_cols 5'b11111, ext_cols 2'b11, frame_done 0, key_event 0, synchronizer flops 1.
REQ-033 Reset asserted mid-SETTLE SHALL release the row the next cycle and restart from WAIT; no partial sample is committed.

Structure
REQ-034 Shared package membrane_pkg SHALL hold NUM_ROWS=8, NUM_COLS=7, ZX_COLS=5, and the scan state enumeration.
REQ-035 Per-key debounce SHALL be sub-module key_debounce (counter plus state bit), instantiated 56 times.
REQ-036 Row and slot counters, the state machine, the synchronizer and the port-read mux SHALL live in membrane_scanner.

Verification (ROW_TICKS=16, DEBOUNCE_SCANS=3)
REQ-037 Reset then idle -> keyb_row_drive 0 for 16 cycles, then 0x01, 0x00 (ADVANCE), 0x02 ... ; frame_done every 128 cycles.
REQ-038 Row 2 col 0 held low for 3 frames -> key_matrix[14] sets after the 3rd row-2 sample; key_event pulses once.
REQ-039 Row 2 col 0 low for 2 frames then released -> key_matrix[14] stays 0; no key_event.
REQ-040 key_matrix[14] set, zx_addr_hi 0xFB -> zx_cols 5'b11110 one cycle later; zx_addr_hi 0x7F -> 5'b11111.
REQ-041 Keys at row 0 col 1 and row 7 col 1 set, zx_addr_hi 0x00 -> zx_cols 5'b11101; col 5 pressed -> ext_cols 2'b10.
REQ-042 Reset pulse mid-SETTLE of row 4 -> keyb_row_drive 0 next cycle; key_matrix 0; scan restarts at row 0 after 16 WAIT cycles.
